// File: rtl/frame_buffer_dbuf.sv
// frame_buffer_dbuf: two-bank frame buffer. The writer fills the back bank,
// the reader scans the front bank, and the banks swap only at reader vsync
// once a complete back frame is pending.
// Optional build macro FB_OVERRUN_CNT_EN adds drop_cnt, a saturating count of
// frame-done pulses that arrive while a completed frame is still waiting.
module frame_buffer_dbuf #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int DATA_W = 16,
  localparam int DEPTH  = H_RES * V_RES,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic              frame_stop,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              w_frame_done,
  input  logic              oe,
  input  logic [ADDR_W-1:0] rAddr,
  input  logic              r_frame_start,
  output logic [DATA_W-1:0] rData,
  output logic              rValid,
  output logic              front_sel,
`ifdef FB_OVERRUN_CNT_EN
  output logic [7:0]        drop_cnt,
`endif
  output logic              frame_ready
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  // One extra bit so DEPTH stays representable when it is a power of two.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];
  logic [0:0]        state;
  logic              wr_en;
  logic              rd_oob;

  // A write lands only while the back frame is still open and the address is real.
  assign wr_en  = (state == FILL) && we && !frame_stop && ({1'b0, wAddr} < DEPTH_W);
  assign rd_oob = ({1'b0, rAddr} >= DEPTH_W);

  // Back-bank write port; the bank being displayed is never written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_sel) bank0[wAddr] <= wData;
      else           bank1[wAddr] <= wData;
    end
  end

  // Swap control: FILL until the writer closes the frame, PEND until vsync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      front_sel   <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (w_frame_done && !frame_stop) state <= PEND;
        end
        PEND: begin
          if (r_frame_start) begin
            front_sel   <= ~front_sel;
            frame_ready <= 1'b1;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Registered read of the front bank; nothing real is shown before the first swap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rData  <= '0;
      rValid <= 1'b0;
    end else begin
      rValid <= oe;
      if (oe) begin
        if (!frame_ready || rd_oob) rData <= '0;
        else if (front_sel)         rData <= bank1[rAddr];
        else                        rData <= bank0[rAddr];
      end
    end
  end

`ifdef FB_OVERRUN_CNT_EN
  // Counts writer frames completed while the previous one was still unshown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= 8'd0;
    end else if ((state == PEND) && w_frame_done && !frame_stop && (drop_cnt != 8'd255)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_buffer_dbuf.sv
// Directed bench for frame_buffer_dbuf using a small 6x5 frame (DEPTH=30,
// 5-bit addresses) so addresses 30/31 exercise the out-of-range path.
module tb_frame_buffer_dbuf;

  localparam int AW = 5;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          we;
  logic          frame_stop;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic          w_frame_done;
  logic          oe;
  logic [AW-1:0] rAddr;
  logic          r_frame_start;
  logic [DW-1:0] rData;
  logic          rValid;
  logic          front_sel;
  logic          frame_ready;
`ifdef FB_OVERRUN_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int passed = 0;
  int total  = 0;

  frame_buffer_dbuf #(.H_RES(6), .V_RES(5), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .frame_stop(frame_stop),
    .wAddr(wAddr), .wData(wData), .w_frame_done(w_frame_done),
    .oe(oe), .rAddr(rAddr), .r_frame_start(r_frame_start),
    .rData(rData), .rValid(rValid), .front_sel(front_sel),
`ifdef FB_OVERRUN_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .frame_ready(frame_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wAddr = a; wData = d;
    tick();
    we = 1'b0;
  endtask

  task automatic pulse_done();
    w_frame_done = 1'b1;
    tick();
    w_frame_done = 1'b0;
  endtask

  task automatic pulse_start();
    r_frame_start = 1'b1;
    tick();
    r_frame_start = 1'b0;
  endtask

  task automatic read_px(input logic [AW-1:0] a);
    oe = 1'b1; rAddr = a;
    tick();
    oe = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; we = 1'b0; frame_stop = 1'b0; wAddr = '0; wData = '0;
    w_frame_done = 1'b0; oe = 1'b0; rAddr = '0; r_frame_start = 1'b0;
    #3;
    check("rst_front_sel", front_sel, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_rvalid", rValid, 0);
    check("rst_rdata", rData, 0);
`ifdef FB_OVERRUN_CNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    tick();
    reset_n = 1'b1;
    tick();

    // Read before any frame is shown returns zero
    read_px(5'd5);
    check("pre_rdata", rData, 0);
    check("pre_rvalid", rValid, 1);
    check("pre_frame_ready", frame_ready, 0);
    check("pre_front_sel", front_sel, 0);
    tick();
    check("oe0_rvalid", rValid, 0);
    check("oe0_rdata_hold", rData, 0);

    // Fill back bank, close frame, try to overwrite in PEND, then swap
    write_px(5'd5, 16'h1234);
    write_px(5'd7, 16'hABCD);
    pulse_done();
    write_px(5'd5, 16'hFFFF);
    check("pend_no_swap", front_sel, 0);
    pulse_start();
    check("swap_front_sel", front_sel, 1);
    check("swap_frame_ready", frame_ready, 1);
    read_px(5'd5);
    check("rd5_data", rData, 16'h1234);
    check("rd5_valid", rValid, 1);
    read_px(5'd7);
    check("rd7_data", rData, 16'hABCD);
    read_px(5'd31);
    check("rd_oob_data", rData, 0);
    check("rd_oob_valid", rValid, 1);
    read_px(5'd7);
    tick();
    check("hold_rvalid", rValid, 0);
    check("hold_rdata", rData, 16'hABCD);

    // frame_stop blocks writes and frame completion
    write_px(5'd5, 16'h1111);
    frame_stop = 1'b1;
    we = 1'b1; wAddr = 5'd5; wData = 16'h5555; w_frame_done = 1'b1;
    tick();
    we = 1'b0; w_frame_done = 1'b0;
    pulse_start();
    check("stop_no_swap", front_sel, 1);
    frame_stop = 1'b0;

    // Done and vsync together in FILL: no swap until a later vsync
    w_frame_done = 1'b1; r_frame_start = 1'b1;
    tick();
    w_frame_done = 1'b0; r_frame_start = 1'b0;
    check("same_cycle_no_swap", front_sel, 1);
    write_px(5'd5, 16'h2222);
    frame_stop = 1'b1;
    pulse_start();
    frame_stop = 1'b0;
    check("stop_allows_swap", front_sel, 0);
    read_px(5'd5);
    check("bank0_rd5", rData, 16'h1111);
    pulse_start();
    check("fill_start_no_swap", front_sel, 0);

    // Reset in the middle of a pending frame
    write_px(5'd5, 16'h3333);
    pulse_done();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_front_sel", front_sel, 0);
    check("mid_rst_frame_ready", frame_ready, 0);
    check("mid_rst_rvalid", rValid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    check("mid_rst_pend_gone", front_sel, 0);
    read_px(5'd5);
    check("mid_rst_rd_zero", rData, 0);
    pulse_done();
    pulse_start();
    check("post_rst_swap", front_sel, 1);
    read_px(5'd5);
    check("retained_rd5", rData, 16'h3333);

`ifdef FB_OVERRUN_CNT_EN
    pulse_done();
    for (int i = 0; i < 3; i++) pulse_done();
    check("drop_cnt_3", drop_cnt, 3);
    for (int i = 0; i < 297; i++) pulse_done();
    check("drop_cnt_sat", drop_cnt, 255);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frame_buffer_dbuf.md
FRAME_BUFFER_DBUF -- requirements
Module: frame_buffer_dbuf

Interface
REQ-001 SHALL have parameter H_RES, default 320, horizontal pixels per frame.
REQ-002 SHALL have parameter V_RES, default 240, lines per frame.
REQ-003 SHALL have parameter DATA_W, default 16, pixel width in bits.
REQ-004 SHALL derive localparam DEPTH = H_RES*V_RES and ADDR_W = $clog2(DEPTH).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-006 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port we, input, 1 bit: pixel write strobe.
REQ-009 SHALL have port frame_stop, input, 1 bit: freezes writes and frame completion.
REQ-010 SHALL have port wAddr, input, ADDR_W bits: write pixel address.
REQ-011 SHALL have port wData, input, DATA_W bits: write pixel data.
REQ-012 SHALL have port w_frame_done, input, 1 bit: single-cycle pulse, writer finished back frame.
REQ-013 SHALL have port oe, input, 1 bit: read enable.
REQ-014 SHALL have port rAddr, input, ADDR_W bits: read pixel address.
REQ-015 SHALL have port r_frame_start, input, 1 bit: single-cycle pulse at reader vsync; the only swap point.
REQ-016 SHALL have port rData, output, DATA_W bits: read pixel.
REQ-017 SHALL have port rValid, output, 1 bit: rData updated this cycle.
REQ-018 SHALL have port front_sel, output, 1 bit: bank currently displayed.
REQ-019 SHALL have port frame_ready, output, 1 bit: at least one complete frame has been swapped to front.

Function
REQ-020 SHALL hold two DEPTH x DATA_W banks; the read bank is front_sel and the write bank is ~front_sel.
REQ-021 SHALL use a two-state FSM: FILL (back bank writable) and PEND (back frame complete, awaiting swap).
REQ-022 In FILL, we=1 with frame_stop=0 and wAddr<DEPTH SHALL write wData to the back bank at the clock edge.
REQ-023 In FILL, w_frame_done=1 with frame_stop=0 SHALL move the FSM to PEND; an r_frame_start in the same cycle SHALL NOT swap.
REQ-024 In PEND, all writes SHALL be ignored, so the completed frame stays intact.
REQ-025 In PEND, r_frame_start SHALL toggle front_sel, set frame_ready=1 (sticky) and return the FSM to FILL on the next edge.
REQ-026 r_frame_start in FILL SHALL have no effect; w_frame_done in PEND SHALL have no effect except as stated in REQ-035.
REQ-027 frame_stop=1 SHALL suppress writes and w_frame_done; it SHALL NOT block a pending swap.
REQ-028 Read latency SHALL be 1 cycle: oe=1 at edge N yields rData=front[rAddr] and rValid=1 after edge N.
REQ-029 With oe=0, rData SHALL hold its value and rValid SHALL be 0.
REQ-030 A read with rAddr>=DEPTH, or any read while frame_ready=0, SHALL return rData=0 with rValid=1.
REQ-031 A read and a write in the same cycle never address the same bank, so no collision rule applies.

Reset
REQ-032 reset_n=0 SHALL immediately force state=FILL, front_sel=0, frame_ready=0, rData=0 and rValid=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 A reset asserted mid-frame SHALL discard the pending state; the partially written back data is retained but not shown.

Configuration
REQ-035 With macro FB_OVERRUN_CNT_EN defined, an output drop_cnt[7:0] SHALL exist: it resets to 0, increments on each w_frame_done received in PEND, and saturates at 255.
REQ-036 Without FB_OVERRUN_CNT_EN, the drop_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Reset, then oe=1 with rAddr=5 -> rData=0, rValid=1, frame_ready=0, front_sel=0.
REQ-038 Write 0x1234 at address 5, pulse w_frame_done, then pulse r_frame_start; read address 5 -> front_sel=1, frame_ready=1, rData=0x1234 one cycle after oe.
REQ-039 In PEND, write 0xFFFF at address 5, then swap -> the address 5 readback is still the pre-PEND value.
REQ-040 frame_stop=1 with we and w_frame_done pulses -> state stays FILL; r_frame_start causes no swap.
REQ-041 Assert w_frame_done and r_frame_start in the same FILL cycle -> no swap; a later r_frame_start swaps.
REQ-042 With FB_OVERRUN_CNT_EN, three w_frame_done pulses in PEND -> drop_cnt=3; after 300 pulses -> drop_cnt=255.
